// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// Carries the sat field only when PIPELINED_CLA_SAT_EN is defined.
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
`ifdef PIPELINED_CLA_SAT_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;
   logic             zero;

`ifdef PIPELINED_CLA_SAT_EN
   modport master (
      output in_valid, a, b, c_in, sub, sat, out_ready,
      input  in_ready, out_valid, s, c_out, ovf, zero
   );
   modport slave (
      input  in_valid, a, b, c_in, sub, sat, out_ready,
      output in_ready, out_valid, s, c_out, ovf, zero
   );
`else
   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, s, c_out, ovf, zero
   );
   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, s, c_out, ovf, zero
   );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, latency WIDTH/(GROUP*GPS) cycles, one op per cycle.
// Optional saturation (sat input, clamp in final stage) is enabled by PIPELINED_CLA_SAT_EN.
module pipelined_cla_adder #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4,
   parameter int GPS   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipelined_cla_adder_if.slave bus
);
   localparam int SLICE  = GROUP * GPS;
   localparam int STAGES = WIDTH / SLICE;
   localparam int LAST   = STAGES - 1;

   generate
      if (WIDTH % SLICE != 0) begin : g_width_check
         $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP*GPS");
      end
   endgenerate

   // Returns {carry_out, carry_into_msb, sum} for one slice; group carries are lookahead.
   function automatic logic [SLICE+1:0] slice_add(
      input logic [SLICE-1:0] x,
      input logic [SLICE-1:0] y,
      input logic             cin
   );
      logic [SLICE-1:0] g;
      logic [SLICE-1:0] p;
      logic [SLICE:0]   c;
      logic [GPS-1:0]   gg;
      logic [GPS-1:0]   gp;
      logic [GPS:0]     gc;
      g     = x & y;
      p     = x ^ y;
      c     = {(SLICE+1){1'b0}};
      gc    = {(GPS+1){1'b0}};
      gc[0] = cin;
      for (int j = 0; j < GPS; j++) begin
         gg[j] = 1'b0;
         gp[j] = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
            gp[j] = gp[j] & p[j*GROUP+i];
         end
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
      for (int j = 0; j < GPS; j++) begin
         c[j*GROUP] = gc[j];
         for (int i = 0; i < GROUP - 1; i++) begin
            c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
         end
      end
      c[SLICE] = gc[GPS];
      return {c[SLICE], c[SLICE-1], p ^ c[SLICE-1:0]};
   endfunction

   // Stage k registers hold the operation about to be resolved by stage k.
   logic [STAGES-1:0] valid_r;
   logic [STAGES-1:0] carry_r;
   logic [STAGES-1:0] sub_r;
   logic [WIDTH-1:0]  a_r   [STAGES];
   logic [WIDTH-1:0]  b_r   [STAGES];
   logic [WIDTH-1:0]  sum_r [STAGES];
`ifdef PIPELINED_CLA_SAT_EN
   logic [STAGES-1:0] sat_r;
`endif

   logic [SLICE+1:0]  res_s  [STAGES];
   logic [WIDTH-1:0]  sum_s  [STAGES];
   logic              cmsb_s [STAGES];
   logic [STAGES-1:0] cout_s;

   logic              adv_s;
   logic [WIDTH-1:0]  s_final_s;
   logic              c_out_s;
   logic              ovf_s;
   logic              zero_s;

   logic              out_valid_r;
   logic [WIDTH-1:0]  s_r;
   logic              c_out_r;
   logic              ovf_r;
   logic              zero_r;

   assign adv_s         = ~out_valid_r | bus.out_ready;
   assign bus.in_ready  = adv_s;
   assign bus.out_valid = out_valid_r;
   assign bus.s         = s_r;
   assign bus.c_out     = c_out_r;
   assign bus.ovf       = ovf_r;
   assign bus.zero      = zero_r;

   // Resolve each stage's slice and merge it into the travelling sum.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         res_s[k]                   = slice_add(a_r[k][k*SLICE +: SLICE], b_r[k][k*SLICE +: SLICE], carry_r[k]);
         sum_s[k]                   = sum_r[k];
         sum_s[k][k*SLICE +: SLICE] = res_s[k][SLICE-1:0];
         cmsb_s[k]                  = res_s[k][SLICE];
         cout_s[k]                  = res_s[k][SLICE+1];
      end
   end

   // Final-stage flags and optional clamp; a set sum MSB on overflow means the true result was positive.
   always_comb begin
      ovf_s   = cmsb_s[LAST] ^ cout_s[LAST];
      c_out_s = sub_r[LAST] ? ~cout_s[LAST] : cout_s[LAST];
`ifdef PIPELINED_CLA_SAT_EN
      if (sat_r[LAST] && ovf_s) begin
         s_final_s = sum_s[LAST][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         s_final_s = sum_s[LAST];
      end
`else
      s_final_s = sum_s[LAST];
`endif
      zero_s = ~|s_final_s;
   end

   // Stage registers: the whole pipe shifts on adv_s and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {STAGES{1'b0}};
         carry_r <= {STAGES{1'b0}};
         sub_r   <= {STAGES{1'b0}};
         for (int k = 0; k < STAGES; k++) begin
            a_r[k]   <= {WIDTH{1'b0}};
            b_r[k]   <= {WIDTH{1'b0}};
            sum_r[k] <= {WIDTH{1'b0}};
         end
      end else if (adv_s) begin
         valid_r[0] <= bus.in_valid;
         a_r[0]     <= bus.a;
         b_r[0]     <= bus.sub ? ~bus.b : bus.b;
         carry_r[0] <= bus.sub ? ~bus.c_in : bus.c_in;
         sub_r[0]   <= bus.sub;
         sum_r[0]   <= {WIDTH{1'b0}};
         for (int k = 1; k < STAGES; k++) begin
            valid_r[k] <= valid_r[k-1];
            a_r[k]     <= a_r[k-1];
            b_r[k]     <= b_r[k-1];
            carry_r[k] <= cout_s[k-1];
            sub_r[k]   <= sub_r[k-1];
            sum_r[k]   <= sum_s[k-1];
         end
      end else begin
         valid_r <= valid_r;
      end
   end

`ifdef PIPELINED_CLA_SAT_EN
   // Saturation request travels alongside its operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_r <= {STAGES{1'b0}};
      end else if (adv_s) begin
         sat_r <= {sat_r[STAGES-1:0] << 1} | {{(STAGES-1){1'b0}}, bus.sat};
      end else begin
         sat_r <= sat_r;
      end
   end
`endif

   // Output register: loads a finished result, keeps fields stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         s_r         <= {WIDTH{1'b0}};
         c_out_r     <= 1'b0;
         ovf_r       <= 1'b0;
         zero_r      <= 1'b0;
      end else if (adv_s) begin
         out_valid_r <= valid_r[LAST];
         if (valid_r[LAST]) begin
            s_r     <= s_final_s;
            c_out_r <= c_out_s;
            ovf_r   <= ovf_s;
            zero_r  <= zero_s;
         end else begin
            s_r     <= s_r;
         end
      end else begin
         out_valid_r <= out_valid_r;
      end
   end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit, 4-bit-group CLA adder.
- Operand width, lookahead group size and groups per pipeline stage are parameters.
- Add/subtract mode, signed overflow and zero flags, and valid/ready handshakes on both sides.
- Sits between operand registers and the ALU result mux; sustains one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of GROUP*GPS.
- GROUP, 4, bits per carry-lookahead group (generate/propagate computed per group).
- GPS, 2, lookahead groups resolved per pipeline stage.
- Derived (not a parameter): STAGES = WIDTH/(GROUP*GPS), which is also the latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 = A+B+c_in; 1 = A-B-c_in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result (mod 2^WIDTH).
- c_out  out  1  add: carry-out; subtract: borrow-out (1 when A < B+c_in, unsigned).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  s == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, s, c_out, ovf and zero clear to 0 immediately. in_ready reads 1 once reset is released. Any operations in flight are discarded with no output.
- Operand conditioning at entry:
  - Internal B = sub ? ~b : b.
  - Internal carry-in = sub ? ~c_in : c_in.
- Per group: G = a&b and P = a^b per bit. Group generate/propagate come from two-level lookahead, as in the existing CLA. Sum bit = P ^ carry.
- Stage k (0..STAGES-1) resolves bit slice [k*GROUP*GPS +: GROUP*GPS] using the carry registered by stage k-1 (stage 0 uses the internal carry-in).
- Unprocessed upper operand bits travel forward in skew registers. Completed lower sum bits travel forward in deskew registers, so all fields of one operation emerge together.
- Latency: an operation accepted at edge N presents its result with out_valid=1 after edge N+STAGES, provided there are no stalls. Throughput is 1 operation per cycle.
- Handshake:
  - adv = ~out_valid | out_ready; in_ready = adv.
  - When adv=1, every stage register shifts by one. Input is captured iff in_valid & in_ready.
  - When adv=0, all stages hold, including bubbles (a global stall; no bubble collapsing).
  - Output fields stay stable while out_valid=1 and out_ready=0.
  - out_valid=1 with out_ready=1 and in_valid=1 in the same cycle: the result retires and the new operand enters. No lost or duplicated operations.
- Flags are computed in the final stage:
  - c_out = sub ? ~carry_msb : carry_msb, where carry_msb is the carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|s.
- The sub and c_in values are captured with their operands and travel with them. Mixed add/sub streams are legal back to back.
- Wrap-around: the sum truncates to WIDTH bits; no exception is raised.
- Parameter legality: WIDTH % (GROUP*GPS) != 0 is an elaboration error (generate-time $error).

Optional Feature:
- Macro: PIPELINED_CLA_SAT_EN.
- Defined: adds input port sat (1 bit), which is captured with its operands.
  - When sat=1 and ovf=1, s is clamped: to 2^(WIDTH-1)-1 if the true result is positive, otherwise to -2^(WIDTH-1).
  - zero is recomputed on the clamped value. ovf is still reported as 1. c_out is unchanged.
  - Latency is unchanged; the clamp mux is in the final stage.
- Not defined: no sat port; results always wrap.

Test Plan:
- WIDTH=16, GROUP=4, GPS=2 (latency 2), out_ready=1: a=0xFFFF, b=0x0001, c_in=0, sub=0 -> two cycles later s=0x0000, c_out=1, ovf=0, zero=1.
- a=0x7FFF, b=0x0001, add -> s=0x8000, ovf=1, c_out=0. With PIPELINED_CLA_SAT_EN and sat=1 -> s=0x7FFF, ovf=1.
- a=0x0003, b=0x0005, sub=1, c_in=0 -> s=0xFFFE, c_out(borrow)=1, ovf=0. Then a=5, b=3, sub=1, c_in=1 -> s=0x0001, c_out=0.
- Back-to-back stream of 8 random operations, out_ready=1 -> 8 results in order at 1 per cycle, first at cycle 2; all match the reference model.
- out_ready held 0 for 3 cycles with the pipeline full -> in_ready=0, s and flags stable, no loss; on release, results resume in order.
- rst_n asserted mid-stream with 2 operations in flight -> out_valid=0 immediately and all outputs 0; after release, the first new operation's result appears 2 cycles after acceptance and no stale result ever appears.
